// File: rtl/sync_feed_fifo_pkg.sv
// Shared constants for the sync_feed_fifo feeder: default word width and
// the FSM state encodings, kept as plain 2-bit constants so they match the
// encodings used by the existing link-side code.
package sync_feed_fifo_pkg;

   localparam int unsigned DATA_WIDTHS = 8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SEND    = 2'd1;
   localparam logic [1:0] ST_WAIT_HI = 2'd2;
   localparam logic [1:0] ST_WAIT_LO = 2'd3;

endpackage

// File: rtl/sync_feed_mem.sv
// sync_feed_mem: DEPTH x DATA_WIDTH register array for the feeder FIFO.
// One synchronous write port, asynchronous read of the head entry.
// The array itself is not reset; occupancy is owned by the pointers in the
// parent, so stale contents are never observed.
module sync_feed_mem #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_W     = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // store accepted producer words
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_feed_fifo.sv
// sync_feed_fifo: upstream feeder for the sync_multi two-flop 4-phase link.
// Queues producer words in a DEPTH-entry FIFO and hands them to the link one
// at a time: a one-cycle tx_v pulse, then wait for the busy flag f to rise
// (bounded by HOLD_MAX cycles) and fall again before the next word.
// Optional feature: define SYNC_FEED_STATS_EN to add the saturating
// sent_cnt / drop_cnt statistics outputs.
module sync_feed_fifo
   import sync_feed_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTHS,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_W     = 2,
   parameter int unsigned HOLD_MAX   = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_W:0]       level,
   output logic                  ovf,
   output logic                  err,
`ifdef SYNC_FEED_STATS_EN
   output logic [15:0]           sent_cnt,
   output logic [15:0]           drop_cnt,
`endif
   input  logic                  f,
   output logic                  tx_v,
   output logic [DATA_WIDTH-1:0] tx_data
);

   localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

   logic [ADDR_W:0]       wr_ptr;
   logic [ADDR_W:0]       rd_ptr;
   logic [1:0]            state;
   logic [CNT_W-1:0]      hold_cnt;
   logic [DATA_WIDTH-1:0] head;
   logic                  wr_ok;
   logic                  wr_drop;
   logic                  pop;

   // occupancy and flags come straight from the registered pointers
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = (level == (ADDR_W + 1)'(DEPTH));
   assign wr_ok   = wr_en && !full;
   assign wr_drop = wr_en && full;
   assign pop     = (state == ST_IDLE) && !empty && !f;

   sync_feed_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (wr_data),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (head)
   );

   // FIFO pointers and sticky overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_drop) begin
            ovf <= 1'b1;
         end
      end
   end

   // link handshake FSM; tx_v is a registered pulse that is high only in SEND
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         tx_v     <= 1'b0;
         tx_data  <= '0;
         hold_cnt <= '0;
         err      <= 1'b0;
      end else begin
         tx_v <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  tx_data <= head;
                  tx_v    <= 1'b1;
                  state   <= ST_SEND;
               end
            end
            ST_SEND: begin
               hold_cnt <= '0;
               state    <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (f) begin
                  hold_cnt <= '0;
                  state    <= ST_WAIT_LO;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
                  // the incremented count reaching HOLD_MAX ends the wait;
                  // comparing against HOLD_MAX-1 avoids a wider adder
                  if (hold_cnt == CNT_W'(HOLD_MAX - 1)) begin
                     err   <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_LO: begin
               if (!f) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SYNC_FEED_STATS_EN
   // saturating statistics: words issued to the link and writes dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         sent_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (pop && (sent_cnt != 16'hFFFF)) begin
            sent_cnt <= sent_cnt + 1'b1;
         end
         if (wr_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_feed_fifo.sv
// Self-checking bench for sync_feed_fifo: a scoreboard queue of accepted
// words is popped and compared whenever tx_v is observed; the bench plays
// the sync_multi side by driving f.
module tb_sync_feed_fifo;

   localparam int unsigned DW       = 8;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned HOLD_MAX = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          empty;
   logic [2:0]    level;
   logic          ovf;
   logic          err;
   logic          f;
   logic          tx_v;
   logic [DW-1:0] tx_data;
`ifdef SYNC_FEED_STATS_EN
   logic [15:0]   sent_cnt;
   logic [15:0]   drop_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] sb[$];

   sync_feed_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .ADDR_W     (2),
      .HOLD_MAX   (HOLD_MAX)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .ovf      (ovf),
      .err      (err),
`ifdef SYNC_FEED_STATS_EN
      .sent_cnt (sent_cnt),
      .drop_cnt (drop_cnt),
`endif
      .f        (f),
      .tx_v     (tx_v),
      .tx_data  (tx_data)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // advance one clock, sample 1ns after the edge, then score any issued word
   task automatic step();
      logic [DW-1:0] exp;
      @(posedge clk);
      #1;
      if (tx_v === 1'b1) begin
         if (sb.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp = sb.pop_front();
            check_val("tx_data", 32'(tx_data), 32'(exp));
         end
      end
      check_val("level", 32'(level), 32'(sb.size()));
   endtask

   task automatic wr(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      if (sb.size() < DEPTH) sb.push_back(d);
      step();
      wr_en = 1'b0;
   endtask

   // play the link after a tx_v pulse: f rises `rise` cycles later, stays high `hi` cycles
   task automatic ack(input int rise, input int hi);
      logic [DW-1:0] held;
      held = tx_data;
      f = 1'b0;
      repeat (rise) begin
         step();
         check_val("wait_hi_tx_v", 32'(tx_v), 32'd0);
         check_val("wait_hi_hold", 32'(tx_data), 32'(held));
      end
      f = 1'b1;
      repeat (hi) begin
         step();
         check_val("busy_tx_v", 32'(tx_v), 32'd0);
         check_val("busy_hold", 32'(tx_data), 32'(held));
      end
      f = 1'b0;
      step();
      check_val("wait_lo_hold", 32'(tx_data), 32'(held));
   endtask

   task automatic serve(input int rise, input int hi, output int waited);
      waited = 0;
      while (tx_v !== 1'b1 && waited < 40) begin
         step();
         waited++;
      end
      if (tx_v !== 1'b1) check_val("serve_timeout", 32'd0, 32'd1);
      else ack(rise, hi);
   endtask

   initial begin
      int w;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      f       = 1'b0;
      sb.delete();
      step();
      step();
      reset = 1'b0;
      check_val("rst_tx_v", 32'(tx_v), 32'd0);
      check_val("rst_tx_data", 32'(tx_data), 32'd0);
      check_val("rst_empty", 32'(empty), 32'd1);
      check_val("rst_full", 32'(full), 32'd0);
      check_val("rst_ovf", 32'(ovf), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);

      // single word latency: loaded at N+1, tx_v for one cycle
      wr(8'hA5);
      check_val("t1_no_early_v", 32'(tx_v), 32'd0);
      check_val("t1_not_empty", 32'(empty), 32'd0);
      step();
      check_val("t1_v", 32'(tx_v), 32'd1);
      check_val("t1_data", 32'(tx_data), 32'hA5);
      ack(2, 3);

      // fill with link busy, then overflow
      f = 1'b1;
      for (int unsigned i = 1; i <= 4; i++) begin
         wr(DW'(i));
         check_val("t2_tx_v", 32'(tx_v), 32'd0);
      end
      check_val("t2_full", 32'(full), 32'd1);
      check_val("t2_ovf_pre", 32'(ovf), 32'd0);
      wr(8'h05);
      check_val("t2_ovf", 32'(ovf), 32'd1);
      check_val("t2_full2", 32'(full), 32'd1);
`ifdef SYNC_FEED_STATS_EN
      check_val("t2_drop_cnt", 32'(drop_cnt), 32'd1);
      check_val("t2_sent_cnt", 32'(sent_cnt), 32'd1);
`endif

      // drain with delayed f; each next word issues one cycle after f falls
      f = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         serve(2, 3, w);
         check_val("t3_next_issue", 32'(w), 32'd1);
      end
      check_val("t3_empty", 32'(empty), 32'd1);

      // f stuck low: err after HOLD_MAX+1 cycles, next word still issues
      wr(8'h11);
      wr(8'h22);
      check_val("t4_v", 32'(tx_v), 32'd1);
      for (int unsigned k = 1; k <= HOLD_MAX + 1; k++) begin
         step();
         check_val("t4_tx_v_low", 32'(tx_v), 32'd0);
         if (k == HOLD_MAX) check_val("t4_err_early", 32'(err), 32'd0);
         if (k == HOLD_MAX + 1) check_val("t4_err", 32'(err), 32'd1);
      end
      step();
      check_val("t4_next_issue", 32'(tx_v), 32'd1);
      ack(2, 3);

      // full FIFO with a write coincident with a pop
      reset = 1'b1;
      sb.delete();
      step();
      reset = 1'b0;
      check_val("t5_err_clr", 32'(err), 32'd0);
      f = 1'b1;
      for (int unsigned i = 0; i < 4; i++) wr(DW'(8'h31 + i));
      check_val("t5_full", 32'(full), 32'd1);
      f = 1'b0;
      wr(8'h99);
      check_val("t5_pop_v", 32'(tx_v), 32'd1);
      check_val("t5_ovf", 32'(ovf), 32'd1);
      check_val("t5_full_after", 32'(full), 32'd0);

      // reset in WAIT_HI with three words queued
      step();
      check_val("t6_wait_tx_v", 32'(tx_v), 32'd0);
      reset = 1'b1;
      sb.delete();
      step();
      reset = 1'b0;
      check_val("t6_tx_v", 32'(tx_v), 32'd0);
      check_val("t6_empty", 32'(empty), 32'd1);
      check_val("t6_tx_data", 32'(tx_data), 32'd0);
      check_val("t6_ovf", 32'(ovf), 32'd0);
`ifdef SYNC_FEED_STATS_EN
      check_val("t6_sent_cnt", 32'(sent_cnt), 32'd0);
      check_val("t6_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
      step();
      check_val("t6_idle_v", 32'(tx_v), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
